// File: rtl/gpio_cfg_serializer.sv
// PL-side master for the RFSoC GPIO config bus: shifts a command word out on sdata (bit 0)
// MSB-first while toggling the selected serial clock line, or fires a single pulse line.
module gpio_cfg_serializer #(
  parameter int GPIO_BUS_WIDTH   = 16,
  parameter int CONFIG_REG_WIDTH = 256,
  parameter int HALF_PERIOD      = 4,
  parameter int LEN_WIDTH        = 9
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [7:0]                  cmd_sel,
  input  logic [LEN_WIDTH-1:0]        cmd_len,
  input  logic [CONFIG_REG_WIDTH-1:0] cmd_data,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [GPIO_BUS_WIDTH-1:0]   gpio_out
);

  localparam int PW = $clog2(HALF_PERIOD + 1);
  localparam int IW = (CONFIG_REG_WIDTH > 1) ? $clog2(CONFIG_REG_WIDTH) : 1;
  localparam logic [PW-1:0]        PH_LAST  = PW'(HALF_PERIOD - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX  = LEN_WIDTH'(CONFIG_REG_WIDTH);
  localparam logic [7:0]           SEL_LAST = 8'd12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_HIGH   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t                      state_r, state_s;
  logic [PW-1:0]               phase_r, phase_s;
  logic [LEN_WIDTH-1:0]        bits_r, bits_s;
  logic [CONFIG_REG_WIDTH-1:0] data_r, data_s;
  logic [7:0]                  sel_r, sel_s;
  logic                        pulse_r, pulse_s;
  logic [GPIO_BUS_WIDTH-1:0]   gpio_r, gpio_s;
  logic                        ready_r, busy_r, done_r, err_r;
  logic                        done_s, err_s;
  logic [LEN_WIDTH-1:0]        len_clamp_s, bit_idx_s;
  logic                        sel_legal_s, sel_pulse_s, sdata_s, line_on_s;

  // Command decode: clamp the length and classify the target line
  always_comb begin
    len_clamp_s = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    sel_pulse_s = (cmd_sel == 8'd5) || (cmd_sel == 8'd6);
    sel_legal_s = (cmd_sel != 8'd0) && (cmd_sel <= SEL_LAST) && (32'(cmd_sel) < GPIO_BUS_WIDTH);
  end

  // Next-state logic; bits counts the bits still to send including the current one
  always_comb begin
    state_s = state_r;
    phase_s = phase_r;
    bits_s  = bits_r;
    data_s  = data_r;
    sel_s   = sel_r;
    pulse_s = pulse_r;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && ready_r) begin
          sel_s   = cmd_sel;
          data_s  = cmd_data;
          pulse_s = sel_pulse_s;
          phase_s = '0;
          bits_s  = len_clamp_s;
          if (!sel_legal_s) begin
            state_s = ST_FINISH;
            done_s  = 1'b1;
            err_s   = 1'b1;
          end else if (sel_pulse_s) begin
            // a pulse is one SETUP+HIGH pair with the line held high throughout
            state_s = ST_SETUP;
            bits_s  = LEN_WIDTH'(1);
          end else if (len_clamp_s == '0) begin
            state_s = ST_FINISH;
            done_s  = 1'b1;
          end else begin
            state_s = ST_SETUP;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (phase_r == PH_LAST) begin
          state_s = ST_HIGH;
          phase_s = '0;
        end else begin
          phase_s = phase_r + PW'(1);
        end
      end
      ST_HIGH: begin
        if (phase_r == PH_LAST) begin
          phase_s = '0;
          if (bits_r <= LEN_WIDTH'(1)) begin
            state_s = ST_FINISH;
            bits_s  = '0;
            done_s  = 1'b1;
          end else begin
            state_s = ST_SETUP;
            bits_s  = bits_r - LEN_WIDTH'(1);
          end
        end else begin
          phase_s = phase_r + PW'(1);
        end
      end
      ST_FINISH: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Bus image for the next cycle, built from the next state so every output is a flop
  always_comb begin
    bit_idx_s = bits_s - LEN_WIDTH'(1);
    gpio_s    = '0;
    if ((state_s == ST_SETUP) || (state_s == ST_HIGH)) begin
      sdata_s   = pulse_s ? 1'b0 : data_s[bit_idx_s[IW-1:0]];
      line_on_s = pulse_s || (state_s == ST_HIGH);
    end else begin
      sdata_s   = 1'b0;
      line_on_s = 1'b0;
    end
    gpio_s[0] = sdata_s;
    for (int i = 1; i < GPIO_BUS_WIDTH; i++) begin
      gpio_s[i] = line_on_s && (32'(sel_s) == i);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      phase_r <= '0;
      bits_r  <= '0;
      data_r  <= '0;
      sel_r   <= 8'd0;
      pulse_r <= 1'b0;
      gpio_r  <= '0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      phase_r <= phase_s;
      bits_r  <= bits_s;
      data_r  <= data_s;
      sel_r   <= sel_s;
      pulse_r <= pulse_s;
      gpio_r  <= gpio_s;
      ready_r <= (state_s == ST_IDLE);
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  assign cmd_ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign gpio_out  = gpio_r;

endmodule

// File: tb/tb_gpio_cfg_serializer.sv
// Directed bench for gpio_cfg_serializer: commands push expectations into a queue; a bus
// monitor collects sdata at each serial clock rise and checks them when done pulses.
module tb_gpio_cfg_serializer;
  localparam int W   = 16;
  localparam int CFG = 256;
  localparam int HP  = 2;
  localparam int LW  = 9;

  logic           clk, rstn, cmd_valid, cmd_ready, busy, done, err;
  logic [7:0]     cmd_sel;
  logic [LW-1:0]  cmd_len;
  logic [CFG-1:0] cmd_data;
  logic [W-1:0]   gpio_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0]     sel;
    int             len;
    logic [CFG-1:0] data;
    int             t;
  } exp_t;
  exp_t q[$];

  gpio_cfg_serializer #(
    .GPIO_BUS_WIDTH(W), .CONFIG_REG_WIDTH(CFG), .HALF_PERIOD(HP), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .busy(busy), .done(done), .err(err), .gpio_out(gpio_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [CFG-1:0] obs, input logic [CFG-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit m_legal(logic [7:0] s);
    return (s >= 8'd1) && (s <= 8'd12) && (int'(s) < W);
  endfunction

  function automatic bit m_pulse(logic [7:0] s);
    return (s == 8'd5) || (s == 8'd6);
  endfunction

  function automatic int m_len(int l);
    return (l > CFG) ? CFG : l;
  endfunction

  function automatic int m_rises(exp_t e);
    if (!m_legal(e.sel)) return 0;
    if (m_pulse(e.sel)) return 1;
    return m_len(e.len);
  endfunction

  function automatic int m_done_cyc(exp_t e);
    if (!m_legal(e.sel)) return e.t + 1;
    if (m_pulse(e.sel)) return e.t + 1 + 2 * HP;
    return e.t + 1 + 2 * m_len(e.len) * HP;
  endfunction

  function automatic logic [CFG-1:0] m_cap(exp_t e);
    logic [CFG-1:0] m;
    m = '0;
    if (!m_legal(e.sel) || m_pulse(e.sel)) return m;
    for (int i = 0; i < m_len(e.len); i++) m[i] = 1'b1;
    return e.data & m;
  endfunction

  function automatic logic [CFG-1:0] rnd256();
    logic [CFG-1:0] d;
    for (int i = 0; i < CFG / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // Bus monitor: sdata bits collected at each serial clock rise, results scored at done
  initial begin : monitor
    int             rises;
    logic [CFG-1:0] cap;
    logic [W-1:0]   prev;
    bit             ready_next;
    exp_t           e;
    rises = 0; cap = '0; prev = '0; ready_next = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        rises = 0; cap = '0; prev = '0; ready_next = 1'b0;
      end else begin
        if (ready_next) begin
          chk("ready_after_done", cmd_ready, 1'b1);
          chk("idle_not_busy", busy, 1'b0);
          chk("done_one_cycle", done, 1'b0);
        end
        ready_next = 1'b0;
        chk("one_line_high", $countones(gpio_out[W-1:1]) <= 1, 1'b1);
        if (!done) chk("err_without_done", err, 1'b0);
        if (gpio_out[0] !== prev[0]) chk("sdata_change_clk_low", gpio_out[W-1:1], '0);
        for (int i = 1; i < W; i++) begin
          if (gpio_out[i] && !prev[i]) begin
            if (q.size() == 0) begin
              chk("spurious_rise", i, 0);
            end else begin
              e = q[0];
              chk("rise_line", i, e.sel);
              chk("rise_cycle", cyc, m_pulse(e.sel) ? e.t + 1 : e.t + 1 + (2 * rises + 1) * HP);
              cap = {cap[CFG-2:0], gpio_out[0]};
              rises++;
            end
          end
        end
        if (done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", done, 1'b0);
          end else begin
            e = q.pop_front();
            chk("done_cycle", cyc, m_done_cyc(e));
            chk("err_flag", err, !m_legal(e.sel));
            chk("rise_count", rises, m_rises(e));
            chk("shifted_bits", cap, m_cap(e));
            chk("bus_idle_at_done", gpio_out, '0);
            chk("busy_at_done", busy, 1'b1);
          end
          rises = 0; cap = '0; ready_next = 1'b1;
        end
        prev = gpio_out;
      end
    end
  end

  task automatic send(input logic [7:0] s, input int l, input logic [CFG-1:0] d,
                      input bit hold, output int t);
    int   n;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = s; cmd_len = LW'(l); cmd_data = d;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    t = -1;
    if (cmd_ready !== 1'b1) begin
      chk("accept_timeout", cmd_ready, 1'b1);
    end else begin
      t = cyc;
      e.sel = s; e.len = l; e.data = d; e.t = t;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || cmd_ready !== 1'b1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size() == 0, 1'b1);
    @(negedge clk);
  endtask

  initial begin : stim
    int t, t1, t2;
    rstn = 1'b1; cmd_valid = 1'b0; cmd_sel = 8'd0; cmd_len = '0; cmd_data = '0;
    #2 rstn = 1'b0;
    #30;
    chk("rst_gpio", gpio_out, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", cmd_ready, 1'b0);
    @(negedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_release", cmd_ready, 1'b1);

    send(8'd3, 4, 256'hA, 1'b0, t);
    drain();
    send(8'd6, 0, '0, 1'b0, t);
    drain();
    send(8'd5, 7, rnd256(), 1'b0, t);
    drain();
    send(8'd0, 4, 256'hF, 1'b0, t);
    drain();
    send(8'd13, 4, 256'hF, 1'b0, t);
    drain();
    send(8'd200, 8, rnd256(), 1'b0, t);
    drain();
    send(8'd2, 0, rnd256(), 1'b0, t);
    drain();
    send(8'd12, 256, {1'b1, 254'd0, 1'b1}, 1'b0, t);
    drain();
    send(8'd4, 300, rnd256(), 1'b0, t);
    drain();
    send(8'd10, 13, rnd256(), 1'b0, t);
    drain();

    // back-to-back with cmd_valid held, then inputs scrambled while busy
    send(8'd1, 5, rnd256(), 1'b1, t1);
    send(8'd9, 3, 256'h5, 1'b0, t2);
    chk("b2b_accept_cycle", t2, t1 + 2 + 2 * 5 * HP);
    cmd_data = rnd256(); cmd_sel = 8'd3; cmd_len = LW'(40);
    drain();

    // reset during bit 2 of an 8-bit command
    send(8'd7, 8, 256'hB5, 1'b0, t);
    while (cyc < t + 1 + 5 * HP) @(negedge clk);
    chk("pre_reset_line_high", gpio_out[7], 1'b1);
    #1 rstn = 1'b0;
    q.delete();
    #1;
    chk("async_rst_gpio", gpio_out, '0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_ready", cmd_ready, 1'b0);
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_reset", cmd_ready, 1'b1);
    send(8'd8, 6, 256'h2D, 1'b0, t);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
